// File: rtl/matrix_result_buffer_pkg.sv
// Shared definitions for the matrix result buffer: FSM encoding and index-width helper.
package matrix_result_buffer_pkg;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DRAIN   = 1'b1;

    // A 1x1 matrix still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_result_buffer_if.sv
// Result-capture and drain handshake bundle between the multiplier, the buffer and the consumer.
interface matrix_result_buffer_if
    import matrix_result_buffer_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = idx_width(N)
);
    logic          clear;
    logic [W-1:0]  z_out;
    logic [IW-1:0] z_i;
    logic [IW-1:0] z_j;
    logic          z_stb;
    logic          z_ack;
    logic [W-1:0]  current_element;
    logic          full;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_i;
    logic [IW-1:0] out_j;
    logic          out_valid;
    logic          out_ready;
    logic          done;

    modport master (
        output clear, z_out, z_i, z_j, z_stb, out_ready,
        input  z_ack, current_element, full, out_data, out_i, out_j, out_valid, done
    );

    modport slave (
        input  clear, z_out, z_i, z_j, z_stb, out_ready,
        output z_ack, current_element, full, out_data, out_i, out_j, out_valid, done
    );
endinterface

// File: rtl/matrix_index_counter.sv
// Row-major [i][j] pointer over an N x N matrix; wraps to [0][0] after the last element.
module matrix_index_counter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);
    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
        end else if (clr) begin
            r_i <= '0;
            r_j <= '0;
        end else if (inc) begin
            if (r_j == MAX_IDX) begin
                r_j <= '0;
                r_i <= (r_i == MAX_IDX) ? '0 : r_i + IW'(1);
            end else begin
                r_j <= r_j + IW'(1);
            end
        end
    end

    assign i    = r_i;
    assign j    = r_j;
    assign last = (r_i == MAX_IDX) && (r_j == MAX_IDX);
endmodule

// File: rtl/matrix_result_buffer.sv
// Collects N x N scattered multiplier results, then drains them row-major over a valid/ready port.
module matrix_result_buffer
    import matrix_result_buffer_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_result_buffer_if.slave bus
);
    localparam int              NN       = N * N;
    localparam int              AW       = idx_width(NN);
    localparam int              CW       = $clog2(NN) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(NN);

    logic [0:0]    r_state;
    logic          r_ack;
    logic          r_full;
    logic          r_done;
    logic [CW-1:0] r_count;
    logic [NN-1:0] r_written;
    logic [W-1:0]  r_mem [NN];

    logic [IW-1:0] w_di;
    logic [IW-1:0] w_dj;
    logic          w_dlast;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic          w_in_range;
    logic          w_capture;
    logic          w_is_new;
    logic [CW-1:0] w_count_nxt;
    logic          w_fill_done;
    logic          w_accept;
    logic          w_drain_end;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        w_waddr     = AW'(int'(bus.z_i) * N + int'(bus.z_j));
        w_raddr     = AW'(int'(w_di) * N + int'(w_dj));
        w_in_range  = (int'(bus.z_i) < N) && (int'(bus.z_j) < N);
        // A strobe seen while acking is the same transfer still held, not a new one.
        w_capture   = (r_state == ST_COLLECT) && bus.z_stb && !r_ack && !bus.clear && w_in_range;
        w_is_new    = w_in_range && !r_written[w_waddr] && (r_count != FULL_CNT);
        w_count_nxt = r_count + CW'(w_is_new);
        w_fill_done = w_capture && (w_count_nxt == FULL_CNT);
        w_accept    = (r_state == ST_DRAIN) && bus.out_ready;
        w_drain_end = w_accept && w_dlast;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_COLLECT;
            r_ack     <= 1'b0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_written <= '0;
        end else if (bus.clear) begin
            r_state   <= ST_COLLECT;
            r_ack     <= 1'b0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_written <= '0;
        end else begin
            r_ack  <= w_capture;
            r_done <= w_drain_end;
            if (w_capture) begin
                r_written[w_waddr] <= 1'b1;
                r_count            <= w_count_nxt;
                if (w_fill_done) begin
                    r_state <= ST_DRAIN;
                    r_full  <= 1'b1;
                end
            end
            if (w_drain_end) begin
                r_state   <= ST_COLLECT;
                r_full    <= 1'b0;
                r_count   <= '0;
                r_written <= '0;
            end
        end
    end

    // NOTE: the storage array is reset and cleared explicitly, so it must stay in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) r_mem[k] <= '0;
        end else if (bus.clear) begin
            for (int k = 0; k < NN; k++) r_mem[k] <= '0;
        end else if (w_capture) begin
            r_mem[w_waddr] <= bus.z_out;
        end
    end

    matrix_index_counter #(.N(N), .IW(IW)) u_drain_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_accept),
        .clr  (bus.clear),
        .i    (w_di),
        .j    (w_dj),
        .last (w_dlast)
    );

    // Stale data survives a drain; the written mask hides it so unwritten entries read as 0.
    assign bus.current_element = (w_in_range && r_written[w_waddr]) ? r_mem[w_waddr] : '0;
    assign bus.z_ack           = r_ack;
    assign bus.full            = r_full;
    assign bus.done            = r_done;
    assign bus.out_valid       = (r_state == ST_DRAIN);
    assign bus.out_data        = r_mem[w_raddr];
    assign bus.out_i           = w_di;
    assign bus.out_j           = w_dj;
endmodule
